// File: rtl/sdrx_frame.sv
// sdrx_frame: hunts for the start bit in 8:1 SERDES sample words and captures one SD command
// response frame (48 or 136 bits). CRC7 check is present only when SDRX_FRAME_CRC_EN is defined.
module sdrx_frame #(
    parameter int unsigned LGTIMEOUT = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [7:0]   i_wide,
    input  logic [7:0]   i_sample_mask,
    input  logic         i_request,
    input  logic         i_long,
    input  logic         i_crc_en,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_timeout,
    output logic         o_crc_err,
    output logic         o_stop_err,
    output logic [135:0] o_resp
);

    typedef enum logic [1:0] {StIdle, StWaitStart, StReceive, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   stop_err_q, stop_err_d;
    logic [135:0]           resp_q, resp_d;
    logic [135:0]           sr_q, sr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [LGTIMEOUT-1:0]   tmo_q, tmo_d;
    logic                   long_q, long_d;

`ifdef SDRX_FRAME_CRC_EN
    logic                   crc_en_q, crc_en_d;
    logic [6:0]             crc_q, crc_d;
    logic                   crc_err_q, crc_err_d;
    logic                   in_crc;
    logic                   fb;
`else
    logic                   unused_crc_en;
    assign unused_crc_en = i_crc_en;
`endif

    // samp[1]/samp_vld[1] is the earliest honoured sample, samp[0] the second one
    logic [1:0]             samp, samp_vld;
    logic                   bit_v, frame_on, fin;
    logic [7:0]             last_idx;

    always_comb begin
        samp     = 2'b00;
        samp_vld = 2'b00;
        for (int i = 7; i >= 0; i--) begin
            if (i_sample_mask[i]) begin
                if (!samp_vld[1]) begin
                    samp_vld[1] = 1'b1;
                    samp[1]     = i_wide[i];
                end else if (!samp_vld[0]) begin
                    samp_vld[0] = 1'b1;
                    samp[0]     = i_wide[i];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        stop_err_d = stop_err_q;
        resp_d     = resp_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        long_d     = long_q;
`ifdef SDRX_FRAME_CRC_EN
        crc_en_d   = crc_en_q;
        crc_d      = crc_q;
        crc_err_d  = crc_err_q;
        in_crc     = 1'b0;
        fb         = 1'b0;
`endif
        bit_v      = 1'b0;
        frame_on   = 1'b0;
        fin        = 1'b0;
        last_idx   = long_q ? 8'd135 : 8'd47;

        case (state_q)
            StIdle: begin
                if (i_request) begin
                    state_d    = StWaitStart;
                    busy_d     = 1'b1;
                    long_d     = i_long;
                    sr_d       = '0;
                    cnt_d      = '0;
                    tmo_d      = '0;
                    resp_d     = '0;
                    timeout_d  = 1'b0;
                    stop_err_d = 1'b0;
`ifdef SDRX_FRAME_CRC_EN
                    crc_en_d   = i_crc_en;
                    crc_d      = '0;
                    crc_err_d  = 1'b0;
`endif
                end
            end
            StWaitStart, StReceive: begin
                frame_on = (state_q == StReceive);
                for (int k = 1; k >= 0; k--) begin
                    if (samp_vld[k] && !fin) begin
                        bit_v = samp[k];
                        // While hunting, leading ones are dropped; the first zero opens the frame
                        if (frame_on || !bit_v) begin
                            frame_on = 1'b1;
`ifdef SDRX_FRAME_CRC_EN
                            in_crc = long_q ? (cnt_d >= 8'd8 && cnt_d < 8'd128)
                                            : (cnt_d < 8'd40);
                            fb     = bit_v ^ crc_d[6];
                            if (in_crc) begin
                                crc_d = {crc_d[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
                            end
`endif
                            sr_d  = {sr_d[134:0], bit_v};
                            fin   = (cnt_d == last_idx);
                            cnt_d = cnt_d + 8'd1;
                        end
                    end
                end
                if (fin) begin
                    state_d = StDone;
                end else if (state_q == StWaitStart) begin
                    if (frame_on) begin
                        state_d = StReceive;
                    end else if (tmo_q == {LGTIMEOUT{1'b1}}) begin
                        state_d   = StIdle;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
                    end
                end
            end
            StDone: begin
                state_d    = StIdle;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                resp_d     = sr_q;
                stop_err_d = ~sr_q[0];
`ifdef SDRX_FRAME_CRC_EN
                crc_err_d  = crc_en_q && (crc_q != sr_q[7:1]);
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            stop_err_q <= 1'b0;
            resp_q     <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            long_q     <= 1'b0;
`ifdef SDRX_FRAME_CRC_EN
            crc_en_q   <= 1'b0;
            crc_q      <= '0;
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            stop_err_q <= stop_err_d;
            resp_q     <= resp_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            long_q     <= long_d;
`ifdef SDRX_FRAME_CRC_EN
            crc_en_q   <= crc_en_d;
            crc_q      <= crc_d;
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;
    assign o_stop_err = stop_err_q;
    assign o_resp     = resp_q;
`ifdef SDRX_FRAME_CRC_EN
    assign o_crc_err  = crc_err_q;
`else
    assign o_crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sdrx_frame.sv
// Bench for sdrx_frame: frames are fed as a bit stream over randomized sample masks and checked
// against a frame-level model (CRC7 over bit ranges, end-bit rule, fixed done latency).
module tb_sdrx_frame;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   wide = 8'hFF;
    logic [7:0]   mask = 8'h00;
    logic         request = 1'b0;
    logic         lng = 1'b0;
    logic         crc_en = 1'b0;
    logic         o_busy, o_done, o_timeout, o_crc_err, o_stop_err;
    logic [135:0] o_resp;

    int checks = 0;
    int failures = 0;

    sdrx_frame #(.LGTIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_wide       (wide),
        .i_sample_mask(mask),
        .i_request    (request),
        .i_long       (lng),
        .i_crc_en     (crc_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_crc_err    (o_crc_err),
        .o_stop_err   (o_stop_err),
        .o_resp       (o_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] f, input int hi, input int lo);
        logic [6:0] c;
        logic       fbk;
        c = 7'h00;
        for (int i = hi; i >= lo; i--) begin
            fbk = f[i] ^ c[6];
            c   = {c[5:0], 1'b0};
            if (fbk) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic exp_crc_err(input logic [135:0] f, input logic lg, input logic ce);
`ifdef SDRX_FRAME_CRC_EN
        logic [6:0] c;
        c = lg ? crc7(f, 127, 8) : crc7(f, 47, 8);
        return ce && (c != f[7:1]);
`else
        return 1'b0 & ce & lg & f[0];
`endif
    endfunction

    function automatic logic [135:0] make_frame(input logic lg);
        logic [135:0] f;
        f = '0;
        if (lg) begin
            for (int i = 8; i < 128; i++) f[i] = ($urandom_range(0, 1) != 0);
            f[135:128] = 8'h3F;
            f[7:1] = crc7(f, 127, 8);
        end else begin
            for (int i = 8; i < 46; i++) f[i] = ($urandom_range(0, 1) != 0);
            f[7:1] = crc7(f, 47, 8);
        end
        f[0] = 1'b1;
        return f;
    endfunction

    // mode 0: fixed mask every cycle; mode 1: random non-zero masks (may exceed two bits)
    task automatic run_frame(input string name, input logic [135:0] f, input logic lg,
                             input logic ce, input int lead, input int mode,
                             input logic [7:0] fmask, input logic [7:0] first_mask,
                             input bit poke);
        bit         q[$];
        int         nbits, cyc, nh;
        logic [7:0] m;
        bit         bad;
        logic       e_crc, e_stop;
        nbits  = lg ? 136 : 48;
        e_crc  = exp_crc_err(f, lg, ce);
        e_stop = ~f[0];

        lng = lg; crc_en = ce; request = 1'b1; mask = 8'h00; wide = 8'hFF;
        step();
        request = 1'b0; lng = ($urandom_range(0, 1) != 0); crc_en = ($urandom_range(0, 1) != 0);
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, o_busy, o_done);
        end

        for (int i = 0; i < lead; i++) q.push_back(1'b1);
        for (int i = nbits - 1; i >= 0; i--) q.push_back(f[i]);

        cyc = 0; bad = 0;
        while (q.size() > 0 && cyc < 400) begin
            if (cyc == 0 && first_mask != 8'h00) m = first_mask;
            else if (mode == 0) m = fmask;
            else begin
                m = 8'($urandom);
                if (m == 8'h00) m = 8'h01;
            end
            wide = 8'($urandom);
            nh = 0;
            for (int i = 7; i >= 0; i--) begin
                if (m[i] && nh < 2) begin
                    nh++;
                    if (q.size() > 0) wide[i] = q.pop_front();
                end
            end
            mask = m;
            request = poke && (cyc == 3);
            if (poke && cyc == 3) lng = ~lg;
            step();
            request = 1'b0;
            cyc++;
            if (o_done !== 1'b0 || o_busy !== 1'b1) bad = 1;
        end
        mask = 8'h00; wide = 8'($urandom);
        step();

        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s during: done/busy wrong while receiving, want done=0 busy=1", name);
        end
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s complete: done=%b busy=%b, want done=1 busy=0", name, o_done, o_busy);
        end
        checks++;
        if (o_resp !== f) begin
            failures++;
            $display("FAIL %s resp: got %h want %h", name, o_resp, f);
        end
        checks++;
        if (o_timeout !== 1'b0 || o_crc_err !== e_crc || o_stop_err !== e_stop) begin
            failures++;
            $display("FAIL %s flags: tmo=%b crc=%b stop=%b, want tmo=0 crc=%b stop=%b",
                     name, o_timeout, o_crc_err, o_stop_err, e_crc, e_stop);
        end
        step();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_resp !== f || o_stop_err !== e_stop) begin
            failures++;
            $display("FAIL %s hold: done=%b busy=%b resp=%h, want done=0 busy=0 resp=%h",
                     name, o_done, o_busy, o_resp, f);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_timeout !== 1'b0 || o_crc_err !== 1'b0 ||
            o_stop_err !== 1'b0 || o_resp !== 136'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b tmo=%b crc=%b stop=%b resp=%h, want all 0",
                     o_busy, o_done, o_timeout, o_crc_err, o_stop_err, o_resp);
        end
    endtask

    task automatic test_short_frames();
        logic [135:0] f;
        f = 136'h08000001AA13;
        run_frame("short_serial", f, 1'b0, 1'b1, 5, 0, 8'h10, 8'h00, 1'b0);
        run_frame("short_dual", f, 1'b0, 1'b1, 10, 0, 8'h88, 8'h00, 1'b0);
        f[20] = ~f[20];
        run_frame("short_flip20", f, 1'b0, 1'b1, 10, 0, 8'h88, 8'h00, 1'b0);
        run_frame("all_ones_mask", make_frame(1'b0), 1'b0, 1'b1, 3, 0, 8'hFF, 8'h00, 1'b0);
    endtask

    task automatic test_r3();
        logic [135:0] f;
        f = 136'h3F00FF8000FF;
        run_frame("r3", f, 1'b0, 1'b0, 2, 1, 8'h00, 8'h00, 1'b0);
        f[0] = 1'b0;
        run_frame("r3_stop", f, 1'b0, 1'b0, 2, 1, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_long();
        // one leading idle bit with a two-sample first mask puts the start bit second
        run_frame("r2_second_pos", make_frame(1'b1), 1'b1, 1'b1, 1, 1, 8'h00, 8'hA0, 1'b0);
        run_frame("r2_poke", make_frame(1'b1), 1'b1, 1'b1, 0, 0, 8'h44, 8'h00, 1'b1);
    endtask

    task automatic test_timeout();
        bit bad;
        request = 1'b1; lng = 1'b0; crc_en = 1'b1; mask = 8'h00;
        step();
        request = 1'b0;
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            mask = 8'h10; wide = 8'hFF;
            step();
            if (k < 16 && (o_done !== 1'b0 || o_busy !== 1'b1)) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout early: done/busy wrong before cycle 16, want done=0 busy=1");
        end
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_busy !== 1'b0 || o_crc_err !== 1'b0 ||
            o_stop_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout at16: done=%b tmo=%b busy=%b crc=%b stop=%b, want 1 1 0 0 0",
                     o_done, o_timeout, o_busy, o_crc_err, o_stop_err);
        end
        mask = 8'h00;
        step();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout after: done=%b busy=%b, want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [135:0] f;
        bit           q[$];
        bit           bad;
        f = make_frame(1'b0);
        request = 1'b1; lng = 1'b0; crc_en = 1'b1; mask = 8'h00;
        step();
        request = 1'b0;
        q.push_back(1'b1);
        q.push_back(1'b1);
        for (int i = 47; i >= 28; i--) q.push_back(f[i]);
        while (q.size() > 0) begin
            wide = 8'($urandom);
            wide[4] = q.pop_front();
            mask = 8'h10;
            step();
        end
        mask = 8'h10; wide = 8'hFF;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_resp !== 136'd0 || o_stop_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b resp=%h, want busy=0 done=0 resp=0",
                     o_busy, o_done, o_resp);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            wide = 8'($urandom);
            step();
            if (o_done !== 1'b0 || o_busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid quiet: done or busy rose after reset, want both 0");
        end
        mask = 8'h00;
        run_frame("after_reset", make_frame(1'b0), 1'b0, 1'b1, 1, 1, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [135:0] f;
        logic         lg, ce;
        int           nb;
        for (int n = 0; n < 8; n++) begin
            lg = ($urandom_range(0, 2) == 0);
            ce = ($urandom_range(0, 3) != 0);
            f  = make_frame(lg);
            nb = lg ? 136 : 48;
            if ($urandom_range(0, 1) != 0) begin
                int p;
                p = $urandom_range(0, nb - 2);
                f[p] = ~f[p];
            end
            run_frame("random", f, lg, ce, $urandom_range(0, 5), 1, 8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_short_frames();
        test_r3();
        test_long();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
